// File: rtl/sem_cfg_master_if.sv
// -----------------------------------------------------------------------------
// sem_cfg_master_if
// Bus bundle between the configuration master and the semaphore block.
//   ctl_wr / ctl_rd       register write / read strobes
//   ctl_addr / ctl_wrdata register address and write data
//   ctl_rddata            register read data, valid the cycle after ctl_rd
//   ram_wr                divisor RAM write strobe
//   ram_addr / ram_wrdata divisor RAM address and write data
// The master modport drives strobes, addresses and write data; the slave
// modport drives ctl_rddata.
// -----------------------------------------------------------------------------
interface sem_cfg_master_if;
    logic        ctl_wr;
    logic        ctl_rd;
    logic [1:0]  ctl_addr;
    logic [31:0] ctl_wrdata;
    logic [31:0] ctl_rddata;
    logic        ram_wr;
    logic [1:0]  ram_addr;
    logic [31:0] ram_wrdata;

    modport master (
        output ctl_wr, ctl_rd, ctl_addr, ctl_wrdata,
        input  ctl_rddata,
        output ram_wr, ram_addr, ram_wrdata
    );

    modport slave (
        input  ctl_wr, ctl_rd, ctl_addr, ctl_wrdata,
        output ctl_rddata,
        input  ram_wr, ram_addr, ram_wrdata
    );
endinterface

// File: rtl/sem_cfg_master.sv
// -----------------------------------------------------------------------------
// sem_cfg_master
// Hardware initiator for the semaphore control/RAM interface.
// On start it loads four divisor words into the responder RAM, writes the
// divisor select register (reg1) and then the enable register (reg0 = 1).
// While running it services host divisor-change requests, polls status reg3
// every POLL_PERIOD idle cycles and, on stop, writes reg0 = 0 and goes idle.
//
// Ports
//   clk        clock, rising edge
//   clrn       asynchronous active-low reset
//   start      pulse: begin init sequence (only honoured when idle)
//   stop       pulse: disable and return to idle (only honoured in RUN)
//   div_req    level: request a reg1 write with div_val, held until div_ack
//   div_val    divisor select for the requested write
//   div_ack    pulse in the cycle the requested reg1 write strobe is driven
//   busy       high whenever a transaction (strobe or gap) is in flight
//   cfg_done   high from the first RUN cycle until back to idle
//   status     last value read from reg3
//   status_vld pulse in the cycle status takes a new value
//   bus        control/RAM bus, master side
//
// Every transaction is one strobe cycle followed by one gap cycle, so strobes
// are never adjacent. All bus outputs are decoded from the state register, so
// an asserted reset removes any strobe immediately.
// -----------------------------------------------------------------------------
module sem_cfg_master #(
    parameter logic [31:0] DIV0        = 32'h0A3C5032,
    parameter logic [31:0] DIV1        = 32'h0A1E0A64,
    parameter logic [31:0] DIV2        = 32'h0A1E281E,
    parameter logic [31:0] DIV3        = 32'h0A463214,
    parameter logic [1:0]  INIT_DIV    = 2'd0,
    parameter int          POLL_PERIOD = 16
) (
    input  logic                    clk,
    input  logic                    clrn,
    input  logic                    start,
    input  logic                    stop,
    input  logic                    div_req,
    input  logic [1:0]              div_val,
    output logic                    div_ack,
    output logic                    busy,
    output logic                    cfg_done,
    output logic [31:0]             status,
    output logic                    status_vld,
    sem_cfg_master_if.master        bus
);

    localparam int TW = $clog2(POLL_PERIOD);
    localparam logic [TW-1:0] POLL_LAST = TW'(POLL_PERIOD - 1);

    typedef enum logic [3:0] {
        S_IDLE,
        S_RAMW,     S_RAMW_GAP,
        S_WDIV,     S_WDIV_GAP,
        S_WEN,      S_WEN_GAP,
        S_RUN,
        S_DIVW,     S_DIVW_GAP,
        S_RD,       S_RDWAIT,
        S_STOPW,    S_STOP_GAP
    } state_e;

    state_e         state_q, state_d;
    logic [1:0]     idx_q, idx_d;       // RAM word being loaded
    logic [TW-1:0]  timer_q, timer_d;   // RUN-idle cycles since last poll
    logic [1:0]     div_q, div_d;       // divisor captured when a request is taken
    logic [31:0]    status_q, status_d;

    logic           ctl_wr, ctl_rd, ram_wr;
    logic [1:0]     ctl_addr, ram_addr;
    logic [31:0]    ctl_wrdata, ram_wrdata;

    function automatic logic [31:0] div_word(input logic [1:0] i);
        case (i)
            2'd0:    div_word = DIV0;
            2'd1:    div_word = DIV1;
            2'd2:    div_word = DIV2;
            default: div_word = DIV3;
        endcase
    endfunction

    // NOTE: state registers use non-blocking assignments so every flop
    // samples the pre-edge value of every other flop.
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            state_q  <= S_IDLE;
            idx_q    <= '0;
            timer_q  <= '0;
            div_q    <= '0;
            status_q <= '0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            timer_q  <= timer_d;
            div_q    <= div_d;
            status_q <= status_d;
        end
    end

    // NOTE: every signal written here gets a default first so no path
    // through the case statement can leave it unassigned and infer a latch.
    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        timer_d    = timer_q;
        div_d      = div_q;
        status_d   = status_q;
        ctl_wr     = 1'b0;
        ctl_rd     = 1'b0;
        ctl_addr   = '0;
        ctl_wrdata = '0;
        ram_wr     = 1'b0;
        ram_addr   = '0;
        ram_wrdata = '0;
        div_ack    = 1'b0;
        status     = status_q;
        status_vld = 1'b0;

        case (state_q)
            S_IDLE: begin
                timer_d = '0;
                idx_d   = '0;
                if (start) state_d = S_RAMW;
            end
            S_RAMW: begin
                ram_wr     = 1'b1;
                ram_addr   = idx_q;
                ram_wrdata = div_word(idx_q);
                state_d    = S_RAMW_GAP;
            end
            S_RAMW_GAP: begin
                idx_d   = idx_q + 2'd1;
                state_d = (idx_q == 2'd3) ? S_WDIV : S_RAMW;
            end
            S_WDIV: begin
                ctl_wr     = 1'b1;
                ctl_addr   = 2'd1;
                ctl_wrdata = {30'b0, INIT_DIV};
                state_d    = S_WDIV_GAP;
            end
            S_WDIV_GAP: state_d = S_WEN;
            S_WEN: begin
                ctl_wr     = 1'b1;
                ctl_addr   = 2'd0;
                ctl_wrdata = 32'd1;
                state_d    = S_WEN_GAP;
            end
            S_WEN_GAP: state_d = S_RUN;
            S_RUN: begin
                // Decision cycle: stop beats a divisor request beats a poll.
                if (stop) begin
                    state_d = S_STOPW;
                end else if (div_req) begin
                    div_d   = div_val;
                    state_d = S_DIVW;
                end else if (timer_q == POLL_LAST) begin
                    timer_d = '0;
                    state_d = S_RD;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            S_DIVW: begin
                ctl_wr     = 1'b1;
                ctl_addr   = 2'd1;
                ctl_wrdata = {30'b0, div_q};
                div_ack    = 1'b1;
                state_d    = S_DIVW_GAP;
            end
            S_DIVW_GAP: state_d = S_RUN;
            S_RD: begin
                ctl_rd   = 1'b1;
                ctl_addr = 2'd3;
                state_d  = S_RD_next();
            end
            S_RDWAIT: begin
                // Read data is valid during the gap; present it straight
                // away and hold it for the following cycles.
                status_d   = bus.ctl_rddata;
                status     = bus.ctl_rddata;
                status_vld = 1'b1;
                state_d    = S_RUN;
            end
            S_STOPW: begin
                ctl_wr     = 1'b1;
                ctl_addr   = 2'd0;
                ctl_wrdata = 32'd0;
                state_d    = S_STOP_GAP;
            end
            S_STOP_GAP: state_d = S_IDLE;
            default:    state_d = S_IDLE;
        endcase
    end

    function automatic state_e S_RD_next();
        S_RD_next = S_RDWAIT;
    endfunction

    assign busy     = (state_q != S_IDLE) && (state_q != S_RUN);
    assign cfg_done = (state_q == S_RUN)    || (state_q == S_DIVW)   ||
                      (state_q == S_DIVW_GAP) || (state_q == S_RD)   ||
                      (state_q == S_RDWAIT) || (state_q == S_STOPW)  ||
                      (state_q == S_STOP_GAP);

    assign bus.ctl_wr     = ctl_wr;
    assign bus.ctl_rd     = ctl_rd;
    assign bus.ctl_addr   = ctl_addr;
    assign bus.ctl_wrdata = ctl_wrdata;
    assign bus.ram_wr     = ram_wr;
    assign bus.ram_addr   = ram_addr;
    assign bus.ram_wrdata = ram_wrdata;

endmodule

// File: tb/tb_sem_cfg_master.sv
// -----------------------------------------------------------------------------
// tb_sem_cfg_master
// Self-checking bench for sem_cfg_master. A transaction-level model keeps a
// queue of expected per-cycle bus beats: each accepted command (start, stop,
// divisor request, poll) appends its strobe and gap beats; an empty queue
// means the master is idle or RUN-idle. One compare process checks every
// cycle against the model; directed sections pin the model with literals.
// -----------------------------------------------------------------------------
module tb_sem_cfg_master;

    localparam int P = 16;

    logic        clk = 1'b0;
    logic        clrn;
    logic        start, stop, div_req;
    logic [1:0]  div_val;
    logic        div_ack, busy, cfg_done, status_vld;
    logic [31:0] status;

    sem_cfg_master_if bus ();

    sem_cfg_master #(.POLL_PERIOD(P)) dut (
        .clk        (clk),
        .clrn       (clrn),
        .start      (start),
        .stop       (stop),
        .div_req    (div_req),
        .div_val    (div_val),
        .div_ack    (div_ack),
        .busy       (busy),
        .cfg_done   (cfg_done),
        .status     (status),
        .status_vld (status_vld),
        .bus        (bus.master)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        ctl_wr;
        logic        ctl_rd;
        logic [1:0]  ctl_addr;
        logic [31:0] ctl_wrdata;
        logic        ram_wr;
        logic [1:0]  ram_addr;
        logic [31:0] ram_wrdata;
        logic        div_ack;
        logic        busy;
        logic        cfg_done;
        logic        status_vld;
    } outs_t;

    typedef struct packed {
        outs_t o;
        logic  rdwait;   // status must equal the read data in this beat
    } beat_t;

    // kind: 1 = RAM write, 2 = register write, 3 = register read
    typedef struct packed {
        logic [1:0]  kind;
        logic [1:0]  addr;
        logic [31:0] data;
        logic        ack;
    } ev_t;

    logic [31:0] div_tbl [4];
    initial begin
        div_tbl[0] = 32'h0A3C5032;
        div_tbl[1] = 32'h0A1E0A64;
        div_tbl[2] = 32'h0A1E281E;
        div_tbl[3] = 32'h0A463214;
    end

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s @%0t: got %h expected %h", name, $time, got, exp);
        end
    endtask

    // ---------------- model ----------------
    beat_t       exp_q[$];
    logic        m_run    = 1'b0;
    int          m_timer  = 0;
    logic [31:0] m_status = '0;

    ev_t         log_q[$];
    int          rd_cyc[$];
    int          cyc      = 0;
    int          ack_cnt  = 0;
    logic        ack_seen = 1'b0;

    function automatic beat_t bt(input logic cw, input logic cr, input logic [1:0] ca,
                                 input logic [31:0] cd, input logic rw, input logic [1:0] ra,
                                 input logic [31:0] rd, input logic ack, input logic bsy,
                                 input logic cfg, input logic vld, input logic rdw);
        beat_t b;
        b.o.ctl_wr     = cw;
        b.o.ctl_rd     = cr;
        b.o.ctl_addr   = ca;
        b.o.ctl_wrdata = cd;
        b.o.ram_wr     = rw;
        b.o.ram_addr   = ra;
        b.o.ram_wrdata = rd;
        b.o.div_ack    = ack;
        b.o.busy       = bsy;
        b.o.cfg_done   = cfg;
        b.o.status_vld = vld;
        b.rdwait       = rdw;
        return b;
    endfunction

    function automatic beat_t gap(input logic cfg);
        return bt(0, 0, 2'd0, 0, 0, 2'd0, 0, 0, 1, cfg, 0, 0);
    endfunction

    function automatic beat_t regw(input logic [1:0] a, input logic [31:0] d,
                                   input logic ack, input logic cfg);
        return bt(1, 0, a, d, 0, 2'd0, 0, ack, 1, cfg, 0, 0);
    endfunction

    always @(negedge clk) begin
        outs_t       act, exp;
        logic [31:0] exp_status;
        beat_t       b;
        cyc++;
        act.ctl_wr     = bus.ctl_wr;
        act.ctl_rd     = bus.ctl_rd;
        act.ctl_addr   = bus.ctl_addr;
        act.ctl_wrdata = bus.ctl_wrdata;
        act.ram_wr     = bus.ram_wr;
        act.ram_addr   = bus.ram_addr;
        act.ram_wrdata = bus.ram_wrdata;
        act.div_ack    = div_ack;
        act.busy       = busy;
        act.cfg_done   = cfg_done;
        act.status_vld = status_vld;

        if (bus.ram_wr) log_q.push_back({2'd1, bus.ram_addr, bus.ram_wrdata, 1'b0});
        if (bus.ctl_wr) log_q.push_back({2'd2, bus.ctl_addr, bus.ctl_wrdata, div_ack});
        if (bus.ctl_rd) begin
            log_q.push_back({2'd3, bus.ctl_addr, 32'd0, 1'b0});
            rd_cyc.push_back(cyc);
        end
        if (div_ack) ack_cnt++;
        ack_seen = div_ack;

        if (!clrn) begin
            check("reset_cycle", {act, status}, '0);
            exp_q.delete();
            m_run    = 1'b0;
            m_timer  = 0;
            m_status = '0;
        end else begin
            if (exp_q.size() > 0) begin
                exp        = exp_q[0].o;
                exp_status = exp_q[0].rdwait ? bus.ctl_rddata : m_status;
            end else begin
                exp        = bt(0, 0, 2'd0, 0, 0, 2'd0, 0, 0, 0, m_run, 0, 0).o;
                exp_status = m_status;
            end
            check("cycle", {act, status}, {exp, exp_status});

            // advance the model with the inputs the next edge will sample
            if (exp_q.size() > 0) begin
                b = exp_q.pop_front();
                if (b.rdwait) m_status = bus.ctl_rddata;
            end else if (!m_run) begin
                if (start) begin
                    for (int i = 0; i < 4; i++) begin
                        exp_q.push_back(bt(0, 0, 2'd0, 0, 1, 2'(i), div_tbl[i], 0, 1, 0, 0, 0));
                        exp_q.push_back(gap(0));
                    end
                    exp_q.push_back(regw(2'd1, 32'd0, 0, 0));
                    exp_q.push_back(gap(0));
                    exp_q.push_back(regw(2'd0, 32'd1, 0, 0));
                    exp_q.push_back(gap(0));
                    m_run   = 1'b1;
                    m_timer = 0;
                end
            end else if (stop) begin
                exp_q.push_back(regw(2'd0, 32'd0, 0, 1));
                exp_q.push_back(gap(1));
                m_run = 1'b0;
            end else if (div_req) begin
                exp_q.push_back(regw(2'd1, {30'b0, div_val}, 1, 1));
                exp_q.push_back(gap(1));
            end else if (m_timer == P - 1) begin
                exp_q.push_back(bt(0, 1, 2'd3, 0, 0, 2'd0, 0, 0, 1, 1, 0, 0));
                exp_q.push_back(bt(0, 0, 2'd0, 0, 0, 2'd0, 0, 0, 1, 1, 1, 1));
                m_timer = 0;
            end else begin
                m_timer++;
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic pulse_start();
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
    endtask

    task automatic wait_cfg_done(input string name);
        logic found = 1'b0;
        for (int n = 0; n < 60; n++) begin
            @(negedge clk);
            if (cfg_done) begin found = 1'b1; break; end
        end
        check(name, found, 1'b1);
    endtask

    task automatic wait_run_idle(input string name, input int want_timer);
        logic found = 1'b0;
        for (int n = 0; n < 4 * P; n++) begin
            @(negedge clk); #1;
            if (exp_q.size() == 0 && m_run && (want_timer < 0 || m_timer == want_timer)) begin
                found = 1'b1;
                break;
            end
        end
        check(name, found, 1'b1);
    endtask

    initial begin
        int   first_ram, done_n;
        logic found;

        clrn = 1'b0; start = 1'b0; stop = 1'b0; div_req = 1'b0; div_val = 2'd0;
        bus.ctl_rddata = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_state", {cfg_done, busy, status_vld, div_ack, bus.ram_wr, status}, '0);
        @(posedge clk); #1 clrn = 1'b1;
        repeat (2) @(posedge clk);

        // 1: init sequence; cycle 0 is the cycle start is high
        #1 bus.ctl_rddata = 32'h0000_0005;
        log_q.delete();
        start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        first_ram = -1; done_n = -1;
        for (int n = 1; n <= 40; n++) begin
            @(negedge clk);
            if (bus.ram_wr && first_ram < 0) first_ram = n;
            if (cfg_done) begin done_n = n; break; end
        end
        check("first_ram_wr_cycle", first_ram, 1);
        check("cfg_done_cycle", done_n, 13);
        check("init_count", log_q.size(), 6);
        for (int i = 0; i < 4; i++)
            if (log_q.size() > i)
                check("init_ram_word", log_q[i], {2'd1, 2'(i), div_tbl[i], 1'b0});
        if (log_q.size() == 6) begin
            check("init_reg1", log_q[4], {2'd2, 2'd1, 32'd0, 1'b0});
            check("init_reg0", log_q[5], {2'd2, 2'd0, 32'd1, 1'b0});
        end

        // 2: polling period and status capture
        @(posedge clk); #1 rd_cyc.delete();
        found = 1'b0;
        for (int n = 0; n < 3 * P; n++) begin
            @(negedge clk);
            if (bus.ctl_rd) begin found = 1'b1; break; end
        end
        check("poll_seen", found, 1'b1);
        @(negedge clk);
        check("status_capture", {status_vld, status}, {1'b1, 32'h0000_0005});
        for (int n = 0; n < 3 * P && rd_cyc.size() < 2; n++) @(negedge clk);
        check("poll_period", (rd_cyc.size() >= 2) ? rd_cyc[1] - rd_cyc[0] : -1, P + 2);

        // 3: divisor request on the poll-due cycle wins, read follows
        wait_run_idle("t3_align", P - 1);
        @(posedge clk); #1 log_q.delete(); div_req = 1'b1; div_val = 2'd2;
        for (int n = 0; n < 10 && !div_ack; n++) @(negedge clk);
        @(posedge clk); #1 div_req = 1'b0;
        repeat (6) @(posedge clk); #1;
        check("t3_first", (log_q.size() > 0) ? log_q[0] : '0, {2'd2, 2'd1, 32'd2, 1'b1});
        check("t3_second", (log_q.size() > 1) ? log_q[1] : '0, {2'd3, 2'd3, 32'd0, 1'b0});

        // 4: stop and divisor request together: only the disable write
        wait_run_idle("t4_align", -1);
        @(posedge clk); #1 stop = 1'b1; div_req = 1'b1; div_val = 2'd1; log_q.delete(); ack_cnt = 0;
        @(posedge clk); #1 stop = 1'b0;
        repeat (3) @(posedge clk); #1 div_req = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("t4_count", log_q.size(), 1);
        check("t4_write", (log_q.size() > 0) ? log_q[0] : '0, {2'd2, 2'd0, 32'd0, 1'b0});
        check("t4_no_ack", ack_cnt, 0);
        check("t4_idle", {cfg_done, busy}, 2'b00);

        // 6: start while already busy or running is ignored
        @(posedge clk); #1 log_q.delete();
        pulse_start();
        repeat (3) @(posedge clk);
        pulse_start();
        wait_cfg_done("t6_init");
        pulse_start();
        repeat (4) @(posedge clk); #1;
        check("t6_no_replay", log_q.size(), 6);
        wait_run_idle("t6_align", -1);
        @(posedge clk); #1 stop = 1'b1;
        @(posedge clk); #1 stop = 1'b0;
        repeat (4) @(posedge clk);

        // 5: reset during the third RAM write, then a clean replay
        #1 log_q.delete();
        pulse_start();
        found = 1'b0;
        for (int n = 0; n < 20; n++) begin
            @(negedge clk);
            if (bus.ram_wr && bus.ram_addr == 2'd2) begin found = 1'b1; break; end
        end
        check("t5_reach_ram2", found, 1'b1);
        #1 clrn = 1'b0;
        #1 check("t5_strobes_drop",
                 {bus.ram_wr, bus.ctl_wr, bus.ctl_rd, bus.ram_addr, bus.ram_wrdata, busy}, '0);
        check("t5_partial_count", log_q.size(), 3);
        repeat (2) @(posedge clk); #1 clrn = 1'b1;
        log_q.delete();
        pulse_start();
        wait_cfg_done("t5_replay_done");
        check("t5_replay_first", (log_q.size() > 0) ? log_q[0] : '0, {2'd1, 2'd0, div_tbl[0], 1'b0});
        check("t5_replay_count", log_q.size(), 6);

        // randomized traffic, model checks every cycle
        for (int n = 0; n < 4000; n++) begin
            @(posedge clk); #1;
            bus.ctl_rddata = $urandom;
            start = ($urandom_range(0, 19) == 0);
            stop  = ($urandom_range(0, 49) == 0);
            if (div_req && ack_seen) div_req = 1'b0;
            else if (!div_req && $urandom_range(0, 9) == 0) begin
                div_req = 1'b1;
                div_val = 2'($urandom_range(0, 3));
            end
            clrn = ($urandom_range(0, 399) != 0);
        end
        @(posedge clk); #1 clrn = 1'b1; start = 1'b0; stop = 1'b0; div_req = 1'b0;
        repeat (5) @(posedge clk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
